// File: rtl/seq_pattern_gen_pkg.sv
// Shared types for the serial pattern transmitter: one-hot FSM encoding and
// the even-parity helper used when SEQGEN_PARITY_EN is defined.
package seq_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'b001,
      SHIFT = 3'b010,
      GAP   = 3'b100
   } state_t;

   // Callers zero-extend their pattern; the padding does not change the XOR.
   function automatic logic even_parity(input logic [63:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a latched PAT_W-bit pattern MSB-first, reps
// times, with optional idle gaps. Define SEQGEN_PARITY_EN to append a parity bit.
module seq_pattern_gen
   import seq_pkg::*;
#(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8,
   parameter int GAP_W = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] reps,
   input  logic [GAP_W-1:0] gap,
   output logic             dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             busy,
   output logic             done
);

   localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

   state_t           r_state;
   logic             r_done;
   logic [PAT_W-1:0] r_pat;
   logic [CNT_W-1:0] r_rep_cnt;
   logic [GAP_W-1:0] r_gap;
   logic [GAP_W-1:0] r_gap_cnt;
   logic [IDX_W-1:0] r_bit_idx;

   logic w_launch;
   logic w_fire;
   logic w_rep_end;
   logic w_last_rep;
   logic w_dout;

   assign w_launch   = (r_state == IDLE) && start && (reps != '0);
   assign w_fire     = (r_state == SHIFT) && dout_ready;
   assign w_last_rep = (r_rep_cnt == CNT_W'(1));

`ifdef SEQGEN_PARITY_EN
   // Set while the parity bit, rather than a pattern bit, is on the line.
   logic r_par_slot;

   assign w_rep_end = w_fire && r_par_slot;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_par_slot <= 1'b0;
      end else if (w_launch || w_rep_end) begin
         r_par_slot <= 1'b0;
      end else if (w_fire && (r_bit_idx == '0)) begin
         r_par_slot <= 1'b1;
      end
   end
`else
   assign w_rep_end = w_fire && (r_bit_idx == '0);
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  if (reps != '0) begin
                     r_state <= SHIFT;
                  end else begin
                     r_done <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               if (w_rep_end) begin
                  if (w_last_rep) begin
                     r_state <= IDLE;
                     r_done  <= 1'b1;
                  end else if (r_gap != '0) begin
                     r_state <= GAP;
                  end
               end
            end
            GAP: begin
               if (r_gap_cnt == GAP_W'(1)) begin
                  r_state <= SHIFT;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Job registers are loaded on launch, so they need no reset.
   always_ff @(posedge clk) begin
      if (w_launch) begin
         r_pat     <= pattern;
         r_rep_cnt <= reps;
         r_gap     <= gap;
         r_bit_idx <= LAST_IDX;
         r_gap_cnt <= gap;
      end else begin
         if (w_rep_end) begin
            r_rep_cnt <= r_rep_cnt - CNT_W'(1);
            r_bit_idx <= LAST_IDX;
            r_gap_cnt <= r_gap;
         end else if (w_fire && (r_bit_idx != '0)) begin
            r_bit_idx <= r_bit_idx - IDX_W'(1);
         end
         if (r_state == GAP) begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
         end
      end
   end

   always_comb begin
      w_dout = 1'b0;
      if (r_state == SHIFT) begin
`ifdef SEQGEN_PARITY_EN
         w_dout = r_par_slot ? even_parity(64'(r_pat)) : r_pat[r_bit_idx];
`else
         w_dout = r_pat[r_bit_idx];
`endif
      end
   end

   assign dout       = w_dout;
   assign dout_valid = (r_state == SHIFT);
   assign busy       = (r_state != IDLE);
   assign done       = r_done;

endmodule
